vga_timing: RTL
===============

Name: vga_timing

Overview:
- Generates raster scan timing for the pong display: horizontal/vertical pixel counters plus HSYNC, VSYNC and a visible-area flag.
- Sits directly upstream of the game engine, driving its PIXEL_H/PIXEL_V inputs and the board's VGA sync pins.
- Sync and visible outputs are delayed to line up with the engine's registered PIXEL colour output.
- Default timing is 800x600 @ 72 Hz on the 50 MHz board clock.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 56, horizontal front porch (clocks)
- H_SYNC, 120, horizontal sync width (clocks)
- H_BACK, 64, horizontal back porch (clocks)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 23, vertical back porch (lines)
- H_SYNC_POL, 1, active level of HSYNC
- V_SYNC_POL, 1, active level of VSYNC
- OUT_DELAY, 1, clocks of delay on HSYNC/VSYNC/VISIBLE relative to PIXEL_H/PIXEL_V; range 0..4

Ports:
- VGA_CLOCK  input  1  pixel clock, 50 MHz
- RESET  input  1  synchronous, active-high reset
- PIXEL_H  output  11  current horizontal count, 0..H_TOTAL-1
- PIXEL_V  output  11  current vertical count, 0..V_TOTAL-1
- HSYNC  output  1  horizontal sync, delayed by OUT_DELAY
- VSYNC  output  1  vertical sync, delayed by OUT_DELAY
- VISIBLE  output  1  high inside the active area, delayed by OUT_DELAY
- FRAME_START  output  1  one-cycle pulse while PIXEL_H==0 and PIXEL_V==0; not delayed
- FRAME_COUNT  output  16  frames completed since reset; wraps

Behaviour:
- Totals: H_TOTAL = sum of the four H_* widths (1040); V_TOTAL = sum of the four V_* widths (666).
- One clock domain, VGA_CLOCK; RESET is sampled on its rising edge only.
- Reset values:
  - PIXEL_H=0, PIXEL_V=0, FRAME_COUNT=0, FRAME_START=0.
  - HSYNC=~H_SYNC_POL, VSYNC=~V_SYNC_POL, VISIBLE=0.
  - Every delay-line stage loads these same inactive values.
- Counting, each clock out of reset:
  - PIXEL_H increments; at H_TOTAL-1 it wraps to 0.
  - PIXEL_V increments only on a PIXEL_H wrap; at V_TOTAL-1 it wraps to 0.
  - FRAME_COUNT increments by 1 on the clock where both counters wrap together, modulo 2^16.
- Undelayed combinational terms, all derived from the registered counters:
  - hs_raw = PIXEL_H in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 856..975.
  - vs_raw = PIXEL_V in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 637..642.
  - vis_raw = PIXEL_H < H_VISIBLE and PIXEL_V < V_VISIBLE.
- Output delay:
  - HSYNC/VSYNC/VISIBLE equal the raw terms passed through an OUT_DELAY-stage register shift line, with polarity applied at the line input.
  - OUT_DELAY=0 means the outputs are combinational from the counters.
- FRAME_START is registered: it is high in the cycle where PIXEL_H==0 and PIXEL_V==0, so the first cycle after reset release does not pulse.
- Reset mid-frame: counters jump to 0 on the next edge and the delay line flushes to inactive values. No partial-sync glitch is allowed: HSYNC may only leave its inactive level through normal counting.
- Widths: all comparisons are 11-bit unsigned. Parameters must satisfy H_TOTAL <= 2047 and V_TOTAL <= 2047; an elaboration-time check fails the build otherwise.
- No handshake; the block is free-running and never stalls.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants for 800x600@72 and 640x480@60;
  - the derived H_TOTAL/V_TOTAL expressions;
  - the COORD_W=11 width constant, also used by the game engine.
- One natural sub-module, sync_delay_line: a parameterised N-stage shift register with a reset value per bit, instantiated once with 3 bits wide.

Test Plan:
- Reset held 5 clocks, then released → PIXEL_H=0,1,2… on successive clocks; HSYNC=0, VSYNC=0, VISIBLE=0 while in reset; VISIBLE=1 starting one clock after PIXEL_H=0 (OUT_DELAY=1).
- Run 1040 clocks → PIXEL_H wraps 1039→0, PIXEL_V goes 0→1 on the same edge; HSYNC high for exactly 120 clocks, rising 1 clock after PIXEL_H=856.
- Run one full frame of 692,640 clocks → exactly one FRAME_START pulse, FRAME_COUNT 0→1; VSYNC high for 6×1040=6240 clocks beginning at line 637; VISIBLE count = 480,000 clocks.
- Assert RESET at PIXEL_H=900, PIXEL_V=640 (inside both syncs) → next clock counters read 0, HSYNC=VSYNC=0; next HSYNC rise after 857 clocks.
- Parameter set H_SYNC_POL=0, V_SYNC_POL=0, OUT_DELAY=0 → sync idles high, goes low combinationally at PIXEL_H=856; reset drives both high.
- Force FRAME_COUNT near wrap with 65,536 frames, or a shortened-timing parameter set → FRAME_COUNT 65535→0 with no effect on counters.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the pong display pipeline.
// Holds default mode timings, derived totals and the coordinate width.
package vga_pkg;

    localparam int unsigned COORD_W       = 11;
    localparam int unsigned FRAME_COUNT_W = 16;
    localparam int unsigned COORD_MAX     = (1 << COORD_W) - 1;

    typedef logic [COORD_W-1:0]       coord_t;
    typedef logic [FRAME_COUNT_W-1:0] frame_count_t;

    // One entry of the sync delay line: polarity already applied.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
    } sync_bits_t;

    // 800x600 @ 72 Hz, 50 MHz pixel clock.
    localparam int unsigned SVGA_H_VISIBLE = 800;
    localparam int unsigned SVGA_H_FRONT   = 56;
    localparam int unsigned SVGA_H_SYNC    = 120;
    localparam int unsigned SVGA_H_BACK    = 64;
    localparam int unsigned SVGA_V_VISIBLE = 600;
    localparam int unsigned SVGA_V_FRONT   = 37;
    localparam int unsigned SVGA_V_SYNC    = 6;
    localparam int unsigned SVGA_V_BACK    = 23;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock.
    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    function automatic int unsigned timing_total(input int unsigned visible,
                                                 input int unsigned front,
                                                 input int unsigned sync,
                                                 input int unsigned back);
        return visible + front + sync + back;
    endfunction

    localparam int unsigned SVGA_H_TOTAL =
        timing_total(SVGA_H_VISIBLE, SVGA_H_FRONT, SVGA_H_SYNC, SVGA_H_BACK);
    localparam int unsigned SVGA_V_TOTAL =
        timing_total(SVGA_V_VISIBLE, SVGA_V_FRONT, SVGA_V_SYNC, SVGA_V_BACK);

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing to the game engine and VGA pins.
interface vga_timing_if;
    import vga_pkg::*;

    coord_t       PIXEL_H;
    coord_t       PIXEL_V;
    logic         HSYNC;
    logic         VSYNC;
    logic         VISIBLE;
    logic         FRAME_START;
    frame_count_t FRAME_COUNT;

    modport master (
        output PIXEL_H, PIXEL_V, HSYNC, VSYNC, VISIBLE, FRAME_START, FRAME_COUNT
    );

    modport slave (
        input PIXEL_H, PIXEL_V, HSYNC, VSYNC, VISIBLE, FRAME_START, FRAME_COUNT
    );

endinterface

// File: rtl/sync_delay_line.sv
// N-stage shift register with a per-bit reset value; DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int unsigned     WIDTH   = 3,
    parameter int unsigned     DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             VGA_CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = VGA_CLOCK ^ RESET;
        assign data_out    = data_in;
    end else begin : g_stages
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge VGA_CLOCK) begin
            if (RESET) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q[0] <= data_in;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_out = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing.sv
// Free-running raster counters with sync/visible outputs delayed to match
// the game engine's registered pixel colour.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = SVGA_H_VISIBLE,
    parameter int unsigned H_FRONT    = SVGA_H_FRONT,
    parameter int unsigned H_SYNC     = SVGA_H_SYNC,
    parameter int unsigned H_BACK     = SVGA_H_BACK,
    parameter int unsigned V_VISIBLE  = SVGA_V_VISIBLE,
    parameter int unsigned V_FRONT    = SVGA_V_FRONT,
    parameter int unsigned V_SYNC     = SVGA_V_SYNC,
    parameter int unsigned V_BACK     = SVGA_V_BACK,
    parameter bit          H_SYNC_POL = 1'b1,
    parameter bit          V_SYNC_POL = 1'b1,
    parameter int unsigned OUT_DELAY  = 1
) (
    input  logic         VGA_CLOCK,
    input  logic         RESET,
    vga_timing_if.master vga
);

    localparam int unsigned H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX || OUT_DELAY > 4) begin : g_param_check
        $error("vga_timing: totals must fit 11 bits and OUT_DELAY must be 0..4");
    end

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST   = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST   = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam sync_bits_t SYNC_IDLE = '{hsync: ~H_SYNC_POL, vsync: ~V_SYNC_POL, visible: 1'b0};

    coord_t       pixel_h_q, pixel_h_d;
    coord_t       pixel_v_q, pixel_v_d;
    frame_count_t frame_count_q, frame_count_d;
    logic         frame_start_q, frame_start_d;
    logic         h_wrap, v_wrap;
    logic         hs_raw, vs_raw, vis_raw;
    sync_bits_t   line_in, line_out;

    always_comb begin
        h_wrap        = (pixel_h_q == H_LAST);
        v_wrap        = (pixel_v_q == V_LAST);
        pixel_h_d     = h_wrap ? '0 : pixel_h_q + coord_t'(1);
        pixel_v_d     = pixel_v_q;
        frame_count_d = frame_count_q;
        if (h_wrap) begin
            pixel_v_d = v_wrap ? '0 : pixel_v_q + coord_t'(1);
        end
        if (h_wrap && v_wrap) begin
            frame_count_d = frame_count_q + frame_count_t'(1);
        end
        // Registered so the pulse lands on the cycle the counters read 0,0.
        frame_start_d = h_wrap && v_wrap;
    end

    always_ff @(posedge VGA_CLOCK) begin
        if (RESET) begin
            pixel_h_q     <= '0;
            pixel_v_q     <= '0;
            frame_count_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_h_q     <= pixel_h_d;
            pixel_v_q     <= pixel_v_d;
            frame_count_q <= frame_count_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        hs_raw  = (pixel_h_q >= HS_FIRST) && (pixel_h_q <= HS_LAST);
        vs_raw  = (pixel_v_q >= VS_FIRST) && (pixel_v_q <= VS_LAST);
        vis_raw = (pixel_h_q < H_VIS_END) && (pixel_v_q < V_VIS_END);
        line_in.hsync   = hs_raw ? H_SYNC_POL : ~H_SYNC_POL;
        line_in.vsync   = vs_raw ? V_SYNC_POL : ~V_SYNC_POL;
        line_in.visible = vis_raw;
    end

    sync_delay_line #(
        .WIDTH   ($bits(sync_bits_t)),
        .DEPTH   (OUT_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay_line (
        .VGA_CLOCK (VGA_CLOCK),
        .RESET     (RESET),
        .data_in   (line_in),
        .data_out  (line_out)
    );

    assign vga.PIXEL_H     = pixel_h_q;
    assign vga.PIXEL_V     = pixel_v_q;
    assign vga.HSYNC       = line_out.hsync;
    assign vga.VSYNC       = line_out.vsync;
    assign vga.VISIBLE     = line_out.visible;
    assign vga.FRAME_START = frame_start_q;
    assign vga.FRAME_COUNT = frame_count_q;

endmodule
